// File: rtl/mem_dump.sv
// Sample-memory read-out: streams 2^SAMPLE_DEPTH bytes, starting at start_addr and wrapping,
// one byte per UART transfer, using the activate/done command handshake.
module mem_dump #(
    parameter int SAMPLE_DEPTH = 8
) (
    input  logic                    clk_50mhz,
    input  logic                    reset,
    input  logic                    activate,
    output logic                    done,
    input  logic [SAMPLE_DEPTH-1:0] start_addr,
    output logic                    mem_en,
    output logic [SAMPLE_DEPTH-1:0] mem_addr,
    input  logic [7:0]              mem_q,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    tx_busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_GUARD = 3'd4;
    localparam logic [2:0] ST_WAIT  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    localparam logic [SAMPLE_DEPTH-1:0] LAST_COUNT = {SAMPLE_DEPTH{1'b1}};
    localparam logic [SAMPLE_DEPTH-1:0] ONE_ADDR   = {{(SAMPLE_DEPTH-1){1'b0}}, 1'b1};

    logic [2:0]              state_r;
    logic [2:0]              state_s;
    logic [SAMPLE_DEPTH-1:0] addr_r;
    logic [SAMPLE_DEPTH-1:0] addr_s;
    logic [SAMPLE_DEPTH-1:0] count_r;
    logic [SAMPLE_DEPTH-1:0] count_s;
    logic [7:0]              data_r;
    logic [7:0]              data_s;
    logic                    start_r;
    logic                    start_s;
    logic                    done_r;
    logic                    done_s;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state_r <= ST_IDLE;
            addr_r  <= {SAMPLE_DEPTH{1'b0}};
            count_r <= {SAMPLE_DEPTH{1'b0}};
            data_r  <= 8'h00;
            start_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            count_r <= count_s;
            data_r  <= data_s;
            start_r <= start_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; activate only matters in IDLE, WAIT and DONE so a byte is never cut short.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (activate) state_s = ST_FETCH;
                else          state_s = ST_IDLE;
            end
            ST_FETCH: state_s = ST_LATCH;
            ST_LATCH: state_s = ST_SEND;
            ST_SEND: begin
                if (tx_busy) state_s = ST_SEND;
                else         state_s = ST_GUARD;
            end
            ST_GUARD: state_s = ST_WAIT;
            ST_WAIT: begin
                if (tx_busy)                    state_s = ST_WAIT;
                else if (count_r == LAST_COUNT) state_s = ST_DONE;
                else if (!activate)             state_s = ST_IDLE;
                else                            state_s = ST_FETCH;
            end
            ST_DONE: begin
                if (activate) state_s = ST_DONE;
                else          state_s = ST_IDLE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, address and byte counter.
    always_comb begin
        addr_s  = addr_r;
        count_s = count_r;
        data_s  = data_r;
        start_s = 1'b0;
        done_s  = done_r;
        case (state_r)
            ST_IDLE: begin
                done_s = 1'b0;
                if (activate) begin
                    addr_s  = start_addr;
                    count_s = {SAMPLE_DEPTH{1'b0}};
                end else begin
                    addr_s  = addr_r;
                    count_s = count_r;
                end
            end
            ST_LATCH: data_s = mem_q;
            ST_SEND: begin
                if (tx_busy) start_s = 1'b0;
                else         start_s = 1'b1;
            end
            ST_WAIT: begin
                // Address wraps naturally at the register width.
                if (!tx_busy && (count_r != LAST_COUNT) && activate) begin
                    addr_s  = addr_r + ONE_ADDR;
                    count_s = count_r + ONE_ADDR;
                end else begin
                    addr_s  = addr_r;
                    count_s = count_r;
                end
            end
            ST_DONE: begin
                if (activate) done_s = 1'b1;
                else          done_s = 1'b0;
            end
            default: begin
                addr_s  = addr_r;
                count_s = count_r;
            end
        endcase
    end

    assign mem_en   = (state_r == ST_FETCH);
    assign mem_addr = addr_r;
    assign tx_data  = data_r;
    assign tx_start = start_r;
    assign done     = done_r;

endmodule

// File: tb/tb_mem_dump.sv
// Directed bench for mem_dump (SAMPLE_DEPTH=3) with a memory model, a UART busy model and
// an expected-byte queue derived from the memory contents and the dump start address.
module tb_mem_dump;

    localparam int DEPTH = 3;
    localparam int NBYTES = 8;

    logic             clk_50mhz = 1'b0;
    logic             reset = 1'b0;
    logic             activate = 1'b0;
    logic             done;
    logic [DEPTH-1:0] start_addr = 3'd0;
    logic             mem_en;
    logic [DEPTH-1:0] mem_addr;
    logic [7:0]       mem_q = 8'h00;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             tx_busy;

    mem_dump #(.SAMPLE_DEPTH(DEPTH)) dut (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .activate  (activate),
        .done      (done),
        .start_addr(start_addr),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_q     (mem_q),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] mem [NBYTES];
    int   busy_len = 0;
    int   busy_cnt = 0;
    logic force_busy = 1'b0;

    logic [7:0] exp_q[$];
    int         pulse_cyc[$];
    logic [7:0] pulse_data[$];
    logic       prev_start = 1'b0;
    logic       prev_busy = 1'b0;
    int         start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk_50mhz) cyc <= cyc + 1;

    // Synchronous-read sample memory
    always @(posedge clk_50mhz) begin
        if (mem_en) mem_q <= mem[mem_addr];
    end

    // UART: busy from the cycle after tx_start is sampled, for busy_len cycles
    always @(posedge clk_50mhz) begin
        if (tx_start && busy_len > 0) busy_cnt <= busy_len;
        else if (busy_cnt > 0)        busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = force_busy | (busy_cnt != 0);

    // Compare process: every tx_start pulse against the expected byte stream
    always @(negedge clk_50mhz) begin
        if (tx_start) begin
            pulse_cyc.push_back(cyc);
            pulse_data.push_back(tx_data);
            check("start_while_busy", {31'd0, prev_busy}, 32'd0);
            check("pulse_width", {31'd0, prev_start}, 32'd0);
            if (exp_q.size() == 0) begin
                check("extra_byte", 32'd1, 32'd0);
            end else begin
                check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        if (done && exp_q.size() != 0) check("done_early", {31'd0, done}, 32'd0);
        prev_start = tx_start;
        prev_busy  = tx_busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50mhz);
        #1;
    endtask

    task automatic start_dump(input logic [DEPTH-1:0] addr);
        exp_q.delete();
        pulse_cyc.delete();
        pulse_data.delete();
        for (int i = 0; i < NBYTES; i++) exp_q.push_back(mem[(int'(addr) + i) % NBYTES]);
        start_addr = addr;
        activate   = 1'b1;
        start_cyc  = cyc;
    endtask

    task automatic wait_done(input int budget, output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            tick(1);
        end
        if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (pulse_cyc.size() >= n) break;
            tick(1);
        end
        if (i == budget) check("pulse_timeout", pulse_cyc.size(), n);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
        check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        check({tag, "_mem_addr"}, {29'd0, mem_addr}, 32'd0);
        check({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    endtask

    initial begin
        int dc;
        for (int i = 0; i < NBYTES; i++) mem[i] = 8'h10 + 8'(i);

        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check_idle_outputs("reset");

        // Full dump from 0 with a 10-cycle UART
        busy_len = 10;
        start_dump(3'd0);
        wait_done(400, dc);
        check("full_count", pulse_cyc.size(), 32'd8);
        check("full_first", {24'd0, pulse_data[0]}, 32'h10);
        check("full_last", {24'd0, pulse_data[7]}, 32'h17);
        tick(5);
        check("done_held", {31'd0, done}, 32'd1);
        check("no_restart", pulse_cyc.size(), 32'd8);
        activate = 1'b0;
        tick(1);
        check("done_fall", {31'd0, done}, 32'd0);
        tick(2);

        // Wrap-around from 5
        start_dump(3'd5);
        wait_done(400, dc);
        check("wrap_count", pulse_cyc.size(), 32'd8);
        check("wrap_first", {24'd0, pulse_data[0]}, 32'h15);
        check("wrap_fourth", {24'd0, pulse_data[3]}, 32'h10);
        check("wrap_last", {24'd0, pulse_data[7]}, 32'h14);
        activate = 1'b0;
        tick(3);

        // Latency and spacing with a UART that never goes busy
        busy_len = 0;
        start_dump(3'd2);
        wait_done(200, dc);
        check("lat_count", pulse_cyc.size(), 32'd8);
        check("lat_first", pulse_cyc[0] - start_cyc, 32'd4);
        for (int i = 1; i < pulse_cyc.size(); i++)
            check("lat_spacing", pulse_cyc[i] - pulse_cyc[i-1], 32'd5);
        check("lat_done", dc - pulse_cyc[7], 32'd3);
        activate = 1'b0;
        tick(3);

        // Busy stall: UART busy before and after activation
        force_busy = 1'b1;
        tick(10);
        start_dump(3'd0);
        tick(50);
        check("stall_no_start", pulse_cyc.size(), 32'd0);
        force_busy = 1'b0;
        start_cyc = cyc;
        wait_pulses(1, 20);
        check("stall_release", pulse_cyc[0] - start_cyc, 32'd1);
        wait_done(200, dc);
        check("stall_count", pulse_cyc.size(), 32'd8);
        activate = 1'b0;
        tick(3);

        // Abort during the 3rd byte's busy period
        busy_len = 10;
        start_dump(3'd4);
        wait_pulses(3, 200);
        tick(2);
        check("abort_busy", {31'd0, tx_busy}, 32'd1);
        activate = 1'b0;
        exp_q.delete();
        tick(40);
        check("abort_count", pulse_cyc.size(), 32'd3);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_uart_idle", {31'd0, tx_busy}, 32'd0);
        start_dump(3'd4);
        wait_done(400, dc);
        check("abort_restart_first", {24'd0, pulse_data[0]}, 32'h14);
        check("abort_restart_count", pulse_cyc.size(), 32'd8);
        activate = 1'b0;
        tick(3);

        // Synchronous reset in the middle of a dump
        start_dump(3'd0);
        wait_pulses(2, 200);
        tick(3);
        exp_q.delete();
        reset = 1'b1;
        tick(1);
        check_idle_outputs("midreset");
        reset = 1'b0;
        activate = 1'b0;
        tick(20);
        check("midreset_no_more", pulse_cyc.size(), 32'd2);
        start_dump(3'd0);
        wait_done(400, dc);
        check("post_reset_count", pulse_cyc.size(), 32'd8);
        check("post_reset_first", {24'd0, pulse_data[0]}, 32'h10);
        activate = 1'b0;
        tick(2);
        check("post_reset_done_fall", {31'd0, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
